sha256_nonce_sweeper: RTL and testbench

Controller that sequences the shared sha256_module core to run a nonce search.
- Takes a 512-bit block template and inserts a 32-bit nonce into one word.
- Issues one hash per nonce over an inclusive range and tests each 256-bit digest for a required count of leading zero bits.
- Stops on the first hit, at range end, on abort, or on a watchdog timeout.
- Sits between the Avalon register front end (which supplies configuration and go/abort) and the sha256 core.

---
 rtl/sha256_nonce_sweeper.sv | 221 ++++++++++++++++++++++
 tb/tb_sha256_nonce_sweeper.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_sweeper.sv
// sha256_nonce_sweeper
// Sequences a shared sha256 core through an inclusive nonce range. For each
// nonce it places the nonce into word NONCE_WORD of the 512-bit block
// template, starts the core, waits for core_done and then tests the digest
// for a required number of leading zero bits. The search stops on the first
// hit, at the end of the range, on abort, or (optionally) on a watchdog
// timeout.
//
// Optional feature: define MINER_WATCHDOG_EN to enable the WAIT-state
// watchdog. When it is undefined, WAIT waits indefinitely and timeout stays 0.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   go, abort          single-cycle start / stop pulses
//   template           512-bit block template (held stable while busy)
//   nonce_start/_end   inclusive nonce range
//   target_zeros       required leading zero bits (clamped to 256)
//   core_start         one-cycle start pulse to the core
//   core_clear         one-cycle clear pulse to the core (also high in reset)
//   core_data          template with the current nonce inserted
//   core_hash          core digest, bit 255 is the MSB
//   core_done          core completion level, held until core_clear
//   busy               search in progress (ISSUE, WAIT, CHECK)
//   found/exhausted/timeout  sticky result flags
//   found_nonce/found_hash   nonce and digest of the hit
//   hash_count         digests checked in this run, saturating
module sha256_nonce_sweeper #(
  parameter int NONCE_WORD     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic         abort,
  input  logic [511:0] template,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [8:0]   target_zeros,
  output logic         core_start,
  output logic         core_clear,
  output logic [511:0] core_data,
  input  logic [255:0] core_hash,
  input  logic         core_done,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hash_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

  state_t         state_q, state_d;
  logic [31:0]    nonce_q, nonce_d;
  logic [511:0]   data_q, data_d;
  logic [31:0]    count_q, count_d;
  logic           found_q, found_d;
  logic           exh_q, exh_d;
  logic           tmo_q, tmo_d;
  logic [31:0]    fnonce_q, fnonce_d;
  logic [255:0]   fhash_q, fhash_d;
  logic           clr_q, clr_d;
  logic           busy_st;

`ifdef MINER_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]    wd_q, wd_d;
`else
  logic           unused_wd;
  assign unused_wd = (TIMEOUT_CYCLES == 0);
`endif

  function automatic logic [511:0] insert_nonce(input logic [511:0] blk,
                                                input logic [31:0]  n);
    logic [511:0] r;
    r = blk;
    r[32*NONCE_WORD +: 32] = n;
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Shifting the digest right by (256 - need) leaves only the top 'need'
  // bits; need = 0 shifts everything out, so it is always a hit.
  function automatic logic is_hit(input logic [255:0] h, input logic [8:0] tz);
    logic [8:0] need;
    need = (tz > 9'd256) ? 9'd256 : tz;
    return (h >> (9'd256 - need)) == 256'd0;
  endfunction

  assign busy_st = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);

  always_comb begin
    state_d  = state_q;
    nonce_d  = nonce_q;
    data_d   = data_q;
    count_d  = count_q;
    found_d  = found_q;
    exh_d    = exh_q;
    tmo_d    = tmo_q;
    fnonce_d = fnonce_q;
    fhash_d  = fhash_q;
    clr_d    = 1'b0;
`ifdef MINER_WATCHDOG_EN
    wd_d     = wd_q;
`endif
    // abort outranks any same-cycle core_done or CHECK decision
    if (abort && busy_st) begin
      state_d = IDLE;
      clr_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            found_d  = 1'b0;
            exh_d    = 1'b0;
            tmo_d    = 1'b0;
            count_d  = 32'd0;
            fnonce_d = 32'd0;
            fhash_d  = 256'd0;
            nonce_d  = nonce_start;
            if (nonce_start > nonce_end) begin
              exh_d   = 1'b1;
              state_d = DONE;
            end else begin
              data_d  = insert_nonce(template, nonce_start);
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          state_d = WAIT;
`ifdef MINER_WATCHDOG_EN
          wd_d    = 32'd0;
`endif
        end
        WAIT: begin
          if (core_done) begin
            state_d = CHECK;
`ifdef MINER_WATCHDOG_EN
          end else if (wd_q == WD_LAST) begin
            tmo_d   = 1'b1;
            clr_d   = 1'b1;
            state_d = DONE;
          end else begin
            wd_d    = wd_q + 32'd1;
`endif
          end
        end
        CHECK: begin
          count_d = sat_inc(count_q);
          if (is_hit(core_hash, target_zeros)) begin
            found_d  = 1'b1;
            fnonce_d = nonce_q;
            fhash_d  = core_hash;
            state_d  = DONE;
          end else if (nonce_q == nonce_end) begin
            // compare before incrementing so the nonce can never wrap
            exh_d    = 1'b1;
            state_d  = DONE;
          end else begin
            nonce_d  = nonce_q + 32'd1;
            data_d   = insert_nonce(template, nonce_q + 32'd1);
            state_d  = ISSUE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      nonce_q  <= 32'd0;
      data_q   <= 512'd0;
      count_q  <= 32'd0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      tmo_q    <= 1'b0;
      fnonce_q <= 32'd0;
      fhash_q  <= 256'd0;
      clr_q    <= 1'b0;
`ifdef MINER_WATCHDOG_EN
      wd_q     <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      nonce_q  <= nonce_d;
      data_q   <= data_d;
      count_q  <= count_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      tmo_q    <= tmo_d;
      fnonce_q <= fnonce_d;
      fhash_q  <= fhash_d;
      clr_q    <= clr_d;
`ifdef MINER_WATCHDOG_EN
      wd_q     <= wd_d;
`endif
    end
  end

  // Reset gates the state-derived strobes so they drop in the reset cycle itself.
  assign core_start  = (state_q == ISSUE) && !reset;
  assign busy        = busy_st && !reset;
  assign core_clear  = reset || clr_q || (state_q == CHECK);
  assign core_data   = data_q;
  assign found       = found_q;
  assign exhausted   = exh_q;
  assign timeout     = tmo_q;
  assign found_nonce = fnonce_q;
  assign found_hash  = fhash_q;
  assign hash_count  = count_q;

endmodule

// File: tb/tb_sha256_nonce_sweeper.sv
module tb_sha256_nonce_sweeper;
  localparam int NW        = 3;
  localparam int CORE_LAT  = 5;             // start edge to first done cycle of the core model
  localparam int PER_NONCE = CORE_LAT + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         go = 1'b0;
  logic         abort = 1'b0;
  logic [511:0] template = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [8:0]   target_zeros = '0;
  logic         core_start, core_clear, busy, found, exhausted, timeout;
  logic [511:0] core_data;
  logic [255:0] core_hash = '0;
  logic         core_done = 1'b0;
  logic [31:0]  found_nonce, hash_count;
  logic [255:0] found_hash;

  int errs = 0;
  int checks = 0;
  int n_done = 0;
  logic stall = 1'b0;
  int unsigned core_cnt = 0;

  typedef struct {
    logic         found, exh, tmo, clr;
    logic [31:0]  start, nonce, count, starts, lat;
    logic [255:0] hash;
  } exp_t;
  exp_t q[$];

  sha256_nonce_sweeper #(.NONCE_WORD(NW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort), .template(template),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target_zeros(target_zeros),
    .core_start(core_start), .core_clear(core_clear), .core_data(core_data),
    .core_hash(core_hash), .core_done(core_done), .busy(busy), .found(found),
    .exhausted(exhausted), .timeout(timeout), .found_nonce(found_nonce),
    .found_hash(found_hash), .hash_count(hash_count));

  always #5 clk = ~clk;

  function automatic logic [255:0] digest(input logic [31:0] n);
    return {~n, {224{1'b1}}};
  endfunction

  // Core model: fixed latency, digest derived from the nonce word it was given.
  always @(posedge clk) begin
    if (core_clear) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else if (core_start) begin
      core_cnt  <= 4;
      core_hash <= digest(core_data[32*NW +: 32]);
    end else if (core_cnt != 0 && !stall) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_done <= 1'b1;
    end
  end

  function automatic int lead_zeros(input logic [31:0] n);
    logic [255:0] h;
    int c;
    c = 0;
    h = digest(n);
    for (int i = 255; i >= 0; i--) begin
      if (h[i]) break;
      c++;
    end
    return c;
  endfunction

  function automatic exp_t model(input logic [31:0] s, input logic [31:0] e, input logic [8:0] tz);
    exp_t r;
    int need;
    r = '{found: 1'b0, exh: 1'b0, tmo: 1'b0, clr: 1'b0, start: s, nonce: '0,
          count: '0, starts: '0, lat: '0, hash: '0};
    need = (tz > 9'd256) ? 256 : int'(tz);
    if (s > e) begin
      r.exh = 1'b1;
      r.lat = 32'd1;
      return r;
    end
    for (longint unsigned n = s; n <= e; n++) begin
      r.count  = r.count + 1;
      r.starts = r.starts + 1;
      if (lead_zeros(n[31:0]) >= need) begin
        r.found = 1'b1;
        r.nonce = n[31:0];
        r.hash  = digest(n[31:0]);
        break;
      end
    end
    if (!r.found) r.exh = 1'b1;
    r.lat = r.count * PER_NONCE + 1;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: tracks each run from the sampled go to the cycle busy is low again.
  bit pending = 1'b0;
  int cyc = 0;
  int starts = 0;
  always @(negedge clk) begin
    exp_t x;
    logic [511:0] expd;
    if (reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        cyc++;
        if (core_start && q.size() > 0) begin
          expd = template;
          expd[32*NW +: 32] = q[0].start + 32'(starts);
          check("core_data_lo", core_data[255:0], expd[255:0]);
          check("core_data_hi", core_data[511:256], expd[511:256]);
          if (starts == 0) check("start_latency", 256'(cyc), 256'(1));
          starts++;
        end
        if (!busy) begin
          pending = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_end: got run end expected none");
          end else begin
            x = q.pop_front();
            check("found", 256'(found), 256'(x.found));
            check("exhausted", 256'(exhausted), 256'(x.exh));
            check("timeout", 256'(timeout), 256'(x.tmo));
            check("end_core_clear", 256'(core_clear), 256'(x.clr));
            check("found_nonce", 256'(found_nonce), 256'(x.nonce));
            check("found_hash", found_hash, x.hash);
            check("hash_count", 256'(hash_count), 256'(x.count));
            check("core_starts", 256'(starts), 256'(x.starts));
            if (x.lat != 0) check("run_latency", 256'(cyc), 256'(x.lat));
          end
          n_done++;
        end
      end
      if (go && !busy) begin
        pending = 1'b1;
        cyc = 0;
        starts = 0;
      end
    end
  end

  task automatic new_template();
    for (int i = 0; i < 16; i++) template[32*i +: 32] = $urandom;
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (n_done == base && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (n_done == base) begin
      errs++;
      $display("FAIL wait_done: got no run end after %0d cycles expected run end", k);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_go(input logic [31:0] s, input logic [31:0] e, input logic [8:0] tz,
                          input logic with_abort);
    nonce_start = s; nonce_end = e; target_zeros = tz;
    go = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    go = 1'b0; abort = 1'b0;
  endtask

  task automatic run(input logic [31:0] s, input logic [31:0] e, input logic [8:0] tz,
                     input logic with_abort);
    int base;
    base = n_done;
    new_template();
    q.push_back(model(s, e, tz));
    pulse_go(s, e, tz, with_abort);
    wait_done(base);
  endtask

  function automatic exp_t stop_item(input logic [31:0] s, input logic tmo, input logic [31:0] lat);
    exp_t r;
    r = '{found: 1'b0, exh: 1'b0, tmo: tmo, clr: 1'b1, start: s, nonce: '0,
          count: '0, starts: 32'd1, lat: lat, hash: '0};
    return r;
  endfunction

  initial begin
    int base;
    logic [31:0] s, e;
    logic [8:0]  tz;

    // reset behaviour
    repeat (2) @(negedge clk);
    check("rst_core_clear", 256'(core_clear), 256'(1));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_core_start", 256'(core_start), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_core_clear", 256'(core_clear), 256'(0));
    check("idle_flags", 256'({found, exhausted, timeout}), 256'(0));
    check("idle_count", 256'(hash_count), 256'(0));
    check("idle_fnonce", 256'(found_nonce), 256'(0));
    check("idle_fhash", found_hash, 256'(0));
    check("idle_core_data", core_data[255:0] | core_data[511:256], 256'(0));
    @(posedge clk); #1;

    // directed runs
    run(32'hEFFF_FFFD, 32'hF000_0010, 9'd4, 1'b0);
    run(32'h10, 32'h1F, 9'd32, 1'b0);
    run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 9'd33, 1'b0);
    run(32'd5, 32'd4, 9'd0, 1'b0);
    run(32'd7, 32'd9, 9'd0, 1'b0);

    // abort in the third WAIT cycle of nonce 0x10
    base = n_done;
    new_template();
    q.push_back(stop_item(32'h10, 1'b0, 32'd0));
    pulse_go(32'h10, 32'h20, 9'd32, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(base);
    run(32'h10, 32'h12, 9'd32, 1'b0);

    // core never completes
    stall = 1'b1;
    base = n_done;
    new_template();
`ifdef MINER_WATCHDOG_EN
    q.push_back(stop_item(32'h100, 1'b1, 32'd18));
    pulse_go(32'h100, 32'h100, 9'd0, 1'b0);
    wait_done(base);
`else
    q.push_back(stop_item(32'h100, 1'b0, 32'd0));
    pulse_go(32'h100, 32'h100, 9'd0, 1'b0);
    repeat (100) begin @(posedge clk); #1; end
    check("stall_busy", 256'(busy), 256'(1));
    check("stall_timeout", 256'(timeout), 256'(0));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(base);
`endif
    stall = 1'b0;

    // reset in the middle of a run
    new_template();
    pulse_go(32'd0, 32'd1000, 9'd300, 1'b0);
    repeat (30) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_count", 256'(hash_count), 256'(0));
    check("midrst_core_clear", 256'(core_clear), 256'(1));
    check("midrst_core_data", core_data[255:0] | core_data[511:256], 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // randomized runs; go is sometimes paired with abort, which go must win
    for (int i = 0; i < 25; i++) begin
      s = $urandom;
      if ($urandom_range(0, 3) == 0) s = 32'hFFFF_FFE8 + 32'($urandom_range(0, 23));
      e = s + 32'($urandom_range(0, 30));
      if ($urandom_range(0, 4) == 0) tz = 9'($urandom_range(256, 511));
      else tz = 9'($urandom_range(0, 6));
      run(s, e, tz, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
